// File: rtl/cr_idx_encoder_pipe.sv
// Purpose: encode a WIDTH-bit select vector (strict one-hot or lowest-set-bit priority) into a binary index plus malformed flag.
// Latency: 1 cycle from accept to out_* when the output register is free; 1 result/cycle sustained.
// Backpressure: output register plus one skid entry; in_ready (registered) drops while the skid entry is occupied.
module cr_idx_encoder_pipe #(
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sel,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);

    // Encoder results for the vector currently offered
    logic [IDX_W-1:0] w_low_idx;
    logic             w_any;
    logic             w_multi;
    logic             w_err;
    logic [IDX_W-1:0] w_idx;

    // Handshake qualifiers
    logic             w_acc;
    logic             w_xfer;

    // Output register, skid register, ready flag and error counter
    logic             r_out_vld;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_err;
    logic             r_skid_vld;
    logic [IDX_W-1:0] r_skid_idx;
    logic             r_skid_err;
    logic             r_in_rdy;
    logic [CNT_W-1:0] r_err_cnt;

    // Lowest set bit position; scanning downwards lets the lowest hit overwrite higher ones
    always_comb begin
        w_low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (in_sel[i]) begin
                w_low_idx = IDX_W'(i);
            end
        end
    end

    // A vector with more than one bit set keeps a bit after clearing its lowest set bit
    assign w_any   = |in_sel;
    assign w_multi = |(in_sel & (in_sel - WIDTH'(1)));
    assign w_err   = !w_any || (!in_mode && w_multi);
    assign w_idx   = w_err ? '0 : w_low_idx;

    assign w_acc   = in_valid && r_in_rdy;
    assign w_xfer  = r_out_vld && out_ready;

    // Output and skid registers: skid drains first, new results fill the first free slot in order
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_idx  <= '0;
            r_out_err  <= 1'b0;
            r_skid_vld <= 1'b0;
            r_skid_idx <= '0;
            r_skid_err <= 1'b0;
        end else if (w_xfer && r_skid_vld) begin
            // No accept can coincide here because in_ready is low while skid is full
            r_out_idx  <= r_skid_idx;
            r_out_err  <= r_skid_err;
            r_out_vld  <= 1'b1;
            r_skid_vld <= 1'b0;
        end else if (w_acc && (!r_out_vld || w_xfer)) begin
            r_out_idx  <= w_idx;
            r_out_err  <= w_err;
            r_out_vld  <= 1'b1;
        end else if (w_acc) begin
            // Output is stalled: park the new result in the skid register
            r_skid_idx <= w_idx;
            r_skid_err <= w_err;
            r_skid_vld <= 1'b1;
        end else if (w_xfer) begin
            r_out_vld  <= 1'b0;
        end
    end

    // in_ready tracks the skid occupancy one cycle later, mirroring the skid valid bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_rdy <= 1'b1;
        end else if (w_xfer && r_skid_vld) begin
            r_in_rdy <= 1'b1;
        end else if (w_acc && r_out_vld && !w_xfer) begin
            r_in_rdy <= 1'b0;
        end
    end

    // Saturating count of malformed accepts; a clear wins but still counts a coincident error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= (w_acc && w_err) ? CNT_W'(1) : '0;
        end else if (w_acc && w_err && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign in_ready  = r_in_rdy;
    assign out_valid = r_out_vld;
    assign out_idx   = r_out_idx;
    assign out_err   = r_out_err;
    assign err_count = r_err_cnt;

endmodule

// File: tb/tb_cr_idx_encoder_pipe.sv
// Purpose: exercise cr_idx_encoder_pipe (8 lines) against a queue-based reference model, two counter widths.
// Latency: model tracks accept/transfer per edge; outputs compared at the falling edge.
// Backpressure: random out_ready stalls plus directed fill/drain and reset-while-full sequences.
module tb_cr_idx_encoder_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_sel;
    logic       in_mode;
    logic       out_ready;
    logic       err_clr;

    logic       in_ready,  in_ready2;
    logic       out_valid, out_valid2;
    logic [2:0] out_idx,   out_idx2;
    logic       out_err,   out_err2;
    logic [7:0] err_count;
    logic [1:0] err_count2;

    int checks   = 0;
    int failures = 0;

    // Reference model state: pending results in delivery order, and error counts
    int q_idx[$];
    bit q_err[$];
    int m_cnt;
    int m_cnt2;

    always #5 clk = ~clk;

    cr_idx_encoder_pipe #(.WIDTH(8), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_err(out_err),
        .err_clr(err_clr), .err_count(err_count)
    );

    cr_idx_encoder_pipe #(.WIDTH(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready2), .in_sel(in_sel), .in_mode(in_mode),
        .out_valid(out_valid2), .out_ready(out_ready), .out_idx(out_idx2), .out_err(out_err2),
        .err_clr(err_clr), .err_count(err_count2)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Encoding rules computed directly from bit counts
    task automatic ref_enc(input logic [7:0] sel, input logic mode, output int idx, output bit err);
        int ones;
        bit found;
        ones  = $countones(sel);
        idx   = 0;
        err   = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i] && !found) begin
                idx   = i;
                found = 1'b1;
            end
        end
        if (ones == 0 || (mode == 1'b0 && ones > 1)) begin
            idx = 0;
            err = 1'b1;
        end
    endtask

    // One clock: decide handshakes from pre-edge model state, update at the edge, compare at negedge
    task automatic tick();
        bit acc, xfer, e;
        int ix;
        acc  = in_valid && (q_idx.size() < 2);
        xfer = (q_idx.size() > 0) && out_ready;
        ref_enc(in_sel, in_mode, ix, e);
        @(posedge clk);
        if (rst) begin
            q_idx.delete();
            q_err.delete();
            m_cnt  = 0;
            m_cnt2 = 0;
        end else begin
            if (xfer) begin
                void'(q_idx.pop_front());
                void'(q_err.pop_front());
            end
            if (acc) begin
                q_idx.push_back(ix);
                q_err.push_back(e);
            end
            if (err_clr) begin
                m_cnt  = (acc && e) ? 1 : 0;
                m_cnt2 = (acc && e) ? 1 : 0;
            end else if (acc && e) begin
                if (m_cnt  < 255) m_cnt++;
                if (m_cnt2 < 3)   m_cnt2++;
            end
        end
        @(negedge clk);
        chk("out_valid", out_valid, q_idx.size() > 0);
        chk("in_ready",  in_ready,  q_idx.size() < 2);
        chk("err_count", err_count, m_cnt);
        chk("d2_out_valid", out_valid2, q_idx.size() > 0);
        chk("d2_in_ready",  in_ready2,  q_idx.size() < 2);
        chk("d2_err_count", err_count2, m_cnt2);
        if (q_idx.size() > 0) begin
            chk("out_idx",    out_idx,  q_idx[0]);
            chk("out_err",    out_err,  q_err[0]);
            chk("d2_out_idx", out_idx2, q_idx[0]);
            chk("d2_out_err", out_err2, q_err[0]);
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] s, input bit m, input bit r, input bit c);
        in_valid  = v;
        in_sel    = s;
        in_mode   = m;
        out_ready = r;
        err_clr   = c;
    endtask

    initial begin
        logic [7:0] tp2 [4];
        logic [7:0] tp4 [3];
        int guard;
        int sat_exp [5];
        tp2 = '{8'h01, 8'h80, 8'h00, 8'h05};
        tp4 = '{8'h02, 8'h04, 8'h10};
        sat_exp = '{1, 2, 3, 3, 3};
        m_cnt  = 0;
        m_cnt2 = 0;

        // Reset
        rst = 1'b1;
        drive(0, 8'h00, 0, 1, 0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_idx",   out_idx,   0);
        chk("rst_out_err",   out_err,   0);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_err_count", err_count, 0);

        // Strict one-hot single result
        drive(1, 8'b00001000, 0, 1, 0);
        tick();
        chk("tp1_valid", out_valid, 1);
        chk("tp1_idx",   out_idx,   3);
        chk("tp1_err",   out_err,   0);
        chk("tp1_cnt",   err_count, 0);

        // Strict back-to-back with malformed vectors
        for (int i = 0; i < 4; i++) begin
            drive(1, tp2[i], 0, 1, 0);
            tick();
        end
        chk("tp2_last_idx", out_idx,   0);
        chk("tp2_last_err", out_err,   1);
        chk("tp2_cnt",      err_count, 2);

        // Priority mode
        drive(1, 8'b01101000, 1, 1, 1);
        tick();
        chk("tp3_idx", out_idx, 3);
        chk("tp3_err", out_err, 0);
        drive(1, 8'h00, 1, 1, 0);
        tick();
        chk("tp3_idx0", out_idx,   0);
        chk("tp3_err0", out_err,   1);
        chk("tp3_cnt",  err_count, 1);
        drive(0, 8'h00, 0, 1, 0);
        tick();

        // Stall: fill output and skid, third vector held by producer
        for (int i = 0; i < 3; i++) begin
            drive(1, tp4[i], 0, 0, 0);
            tick();
        end
        chk("tp4_in_ready", in_ready, 0);
        chk("tp4_head_idx", out_idx,  1);
        tick();
        chk("tp4_hold_idx", out_idx,  1);
        out_ready = 1'b1;
        guard = 0;
        while (q_idx.size() != 1 || q_idx[0] != 4) begin
            if (in_valid && q_idx.size() < 2) begin
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
            guard++;
            if (guard > 20) begin
                chk("tp4_drain_timeout", guard, 0);
                break;
            end
        end
        chk("tp4_last_idx", out_idx, 4);
        drive(0, 8'h00, 0, 1, 0);
        tick();

        // Saturation on the 2-bit counter
        drive(0, 8'h00, 0, 1, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 8'h00, 0, 1, 0);
            tick();
            chk("tp5_sat", err_count2, sat_exp[i]);
        end
        drive(0, 8'h00, 0, 1, 1);
        tick();
        chk("tp5_clr", err_count2, 0);
        drive(1, 8'h00, 0, 1, 1);
        tick();
        chk("tp5_clr_err", err_count2, 1);

        // Reset while both registers are full
        drive(1, 8'h01, 0, 0, 0);
        tick();
        drive(1, 8'h03, 0, 0, 0);
        tick();
        chk("tp6_full", in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("tp6_out_valid", out_valid, 0);
        chk("tp6_in_ready",  in_ready,  1);
        chk("tp6_cnt",       err_count, 0);
        drive(1, 8'h40, 0, 1, 0);
        tick();
        chk("tp6_idx", out_idx, 6);
        chk("tp6_err", out_err, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int kind;
            logic [7:0] s;
            kind = $urandom_range(0, 3);
            case (kind)
                0: s = 8'h01 << $urandom_range(0, 7);
                1: s = 8'h00;
                default: s = 8'($urandom);
            endcase
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 9) < 7, s, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
